// File: rtl/change_dispenser.sv
// change_dispenser: accepts a refund amount over a valid/ready handshake.
// It breaks the amount greedily into 50/10/5 coins and ejects one coin per
// pulse, with GAP idle cycles between consecutive pulses. Any residue
// below 5 is dropped and flagged on residue_err together with done.

module change_dispenser #(
    parameter int AMT_W = 7,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund_amount,
    output logic             refund_ready,
    output logic             coin_out_50,
    output logic             coin_out_10,
    output logic             coin_out_5,
    output logic [AMT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             residue_err
);

    // The gap counter must be able to hold the value GAP itself.
    localparam int CNT_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

    localparam logic [AMT_W-1:0] COIN_50 = AMT_W'(50);
    localparam logic [AMT_W-1:0] COIN_10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] COIN_5  = AMT_W'(5);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_GAP      = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] remaining_n;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_n;
    logic             coin_50_q;
    logic             coin_50_n;
    logic             coin_10_q;
    logic             coin_10_n;
    logic             coin_5_q;
    logic             coin_5_n;
    logic             done_q;
    logic             done_n;
    logic             residue_q;
    logic             residue_n;
    logic             handshake;

    // A request is taken only while idle; later changes on the amount are ignored.
    assign handshake = refund_valid && (state == S_IDLE);

    // State, amount, gap counter and the one-cycle output pulses are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            remaining_q <= '0;
            gap_cnt     <= '0;
            coin_50_q   <= 1'b0;
            coin_10_q   <= 1'b0;
            coin_5_q    <= 1'b0;
            done_q      <= 1'b0;
            residue_q   <= 1'b0;
        end else begin
            state       <= state_n;
            remaining_q <= remaining_n;
            gap_cnt     <= gap_cnt_n;
            coin_50_q   <= coin_50_n;
            coin_10_q   <= coin_10_n;
            coin_5_q    <= coin_5_n;
            done_q      <= done_n;
            residue_q   <= residue_n;
        end
    end

    // Next-state and next-output decode: one greedy coin decision per DISPENSE cycle.
    always_comb begin
        state_n     = state;
        remaining_n = remaining_q;
        gap_cnt_n   = gap_cnt;
        coin_50_n   = 1'b0;
        coin_10_n   = 1'b0;
        coin_5_n    = 1'b0;
        done_n      = 1'b0;
        residue_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (handshake) begin
                    remaining_n = refund_amount;
                    state_n     = S_DISPENSE;
                end
            end

            S_DISPENSE: begin
                if (remaining_q >= COIN_50) begin
                    coin_50_n   = 1'b1;
                    remaining_n = remaining_q - COIN_50;
                    gap_cnt_n   = GAP_LOAD;
                    state_n     = S_GAP;
                end else if (remaining_q >= COIN_10) begin
                    coin_10_n   = 1'b1;
                    remaining_n = remaining_q - COIN_10;
                    gap_cnt_n   = GAP_LOAD;
                    state_n     = S_GAP;
                end else if (remaining_q >= COIN_5) begin
                    coin_5_n    = 1'b1;
                    remaining_n = remaining_q - COIN_5;
                    gap_cnt_n   = GAP_LOAD;
                    state_n     = S_GAP;
                end else begin
                    done_n      = 1'b1;
                    residue_n   = (remaining_q != '0);
                    remaining_n = '0;
                    state_n     = S_IDLE;
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = S_DISPENSE;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_LAST;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign refund_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign coin_out_50  = coin_50_q;
    assign coin_out_10  = coin_10_q;
    assign coin_out_5   = coin_5_q;
    assign remaining    = remaining_q;
    assign done         = done_q;
    assign residue_err  = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with GAP=1 and one with
// GAP=2, checked edge by edge against hand-computed coin schedules.

module tb_change_dispenser;

    logic       clk;
    logic       rst_n;

    logic       valid_a;
    logic [6:0] amount_a;
    logic       ready_a;
    logic       c50_a;
    logic       c10_a;
    logic       c5_a;
    logic [6:0] rem_a;
    logic       busy_a;
    logic       done_a;
    logic       res_a;

    logic       valid_b;
    logic [6:0] amount_b;
    logic       ready_b;
    logic       c50_b;
    logic       c10_b;
    logic       c5_b;
    logic [6:0] rem_b;
    logic       busy_b;
    logic       done_b;
    logic       res_b;

    int tests_run;
    int tests_failed;

    logic [2:0] exp_coin [0:31];
    logic [6:0] exp_rem_after [0:31];

    change_dispenser #(.AMT_W(7), .GAP(1)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .refund_valid  (valid_a),
        .refund_amount (amount_a),
        .refund_ready  (ready_a),
        .coin_out_50   (c50_a),
        .coin_out_10   (c10_a),
        .coin_out_5    (c5_a),
        .remaining     (rem_a),
        .busy          (busy_a),
        .done          (done_a),
        .residue_err   (res_a)
    );

    change_dispenser #(.AMT_W(7), .GAP(2)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .refund_valid  (valid_b),
        .refund_amount (amount_b),
        .refund_ready  (ready_b),
        .coin_out_50   (c50_b),
        .coin_out_10   (c10_b),
        .coin_out_5    (c5_b),
        .remaining     (rem_b),
        .busy          (busy_b),
        .done          (done_b),
        .residue_err   (res_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one instance's outputs as {ready, busy, done, res, c50, c10, c5, remaining}.
    function automatic logic [13:0] obs(input int sel);
        if (sel == 1)
            return {ready_b, busy_b, done_b, res_b, c50_b, c10_b, c5_b, rem_b};
        return {ready_a, busy_a, done_a, res_a, c50_a, c10_a, c5_a, rem_a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [6:0] amt);
        @(negedge clk);
        if (sel == 1) begin
            valid_b  = 1'b1;
            amount_b = amt;
        end else begin
            valid_a  = 1'b1;
            amount_a = amt;
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 32; i++) begin
            exp_coin[i]      = 3'b000;
            exp_rem_after[i] = 7'd0;
        end
    endtask

    task automatic plan_coin(input int e, input logic [2:0] code, input logic [6:0] rem_after);
        exp_coin[e]      = code;
        exp_rem_after[e] = rem_after;
    endtask

    // Handshake edge E0 comes next; then edges 1..done_edge are checked against the plan.
    task automatic run_request(input string name, input int sel, input logic [6:0] amt,
                               input int done_edge, input logic exp_res,
                               input logic keep_valid, input logic [6:0] next_amt);
        logic [13:0] o;
        logic [6:0]  exp_rem;
        @(posedge clk);
        #1;
        o = obs(sel);
        checkOutput({name, " E0 busy"}, 32'(o[12]), 32'd1);
        checkOutput({name, " E0 remaining"}, 32'(o[6:0]), 32'(amt));
        if (sel == 1) begin
            if (keep_valid) amount_b = next_amt; else valid_b = 1'b0;
        end else begin
            if (keep_valid) amount_a = next_amt; else valid_a = 1'b0;
        end
        exp_rem = amt;
        for (int e = 1; e <= done_edge; e++) begin
            @(posedge clk);
            #1;
            o = obs(sel);
            if (exp_coin[e] != 3'b000) exp_rem = exp_rem_after[e];
            if (e == done_edge) exp_rem = 7'd0;
            checkOutput($sformatf("%s E%0d coins", name, e), 32'(o[9:7]), 32'(exp_coin[e]));
            checkOutput($sformatf("%s E%0d remaining", name, e), 32'(o[6:0]), 32'(exp_rem));
            checkOutput($sformatf("%s E%0d done", name, e), 32'(o[11]),
                        (e == done_edge) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s E%0d residue", name, e), 32'(o[10]),
                        (e == done_edge) ? 32'(exp_res) : 32'd0);
            checkOutput($sformatf("%s E%0d ready", name, e), 32'(o[13]),
                        (e == done_edge) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s E%0d busy", name, e), 32'(o[12]),
                        (e == done_edge) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic idle_check(input string name, input int sel);
        logic [13:0] o;
        @(posedge clk);
        #1;
        o = obs(sel);
        checkOutput({name, " after done"}, 32'(o), 32'h2000);
    endtask

    // Main directed sequence.
    initial begin
        logic [13:0] o;
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b1;
        valid_a  = 1'b0;
        amount_a = 7'd0;
        valid_b  = 1'b0;
        amount_b = 7'd0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset A outputs", 32'(obs(0)), 32'h2000);
        checkOutput("reset B outputs", 32'(obs(1)), 32'h2000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 65 with GAP=1: 50, 10, 5 then done at E7.
        clear_plan();
        plan_coin(1, 3'b100, 7'd15);
        plan_coin(3, 3'b010, 7'd5);
        plan_coin(5, 3'b001, 7'd0);
        applyStimulus(0, 7'd65);
        run_request("amt65", 0, 7'd65, 7, 1'b0, 1'b0, 7'd0);
        idle_check("amt65", 0);

        // Zero amount: done at E1, no coins.
        clear_plan();
        applyStimulus(0, 7'd0);
        run_request("amt0", 0, 7'd0, 1, 1'b0, 1'b0, 7'd0);
        idle_check("amt0", 0);

        // Residue only: 3 is dropped and flagged.
        clear_plan();
        applyStimulus(0, 7'd3);
        run_request("amt3", 0, 7'd3, 1, 1'b1, 1'b0, 7'd0);
        idle_check("amt3", 0);

        // 127 with GAP=2: 50, 50, 10, 10, 5 then done with residue at E16.
        clear_plan();
        plan_coin(1,  3'b100, 7'd77);
        plan_coin(4,  3'b100, 7'd27);
        plan_coin(7,  3'b010, 7'd17);
        plan_coin(10, 3'b010, 7'd7);
        plan_coin(13, 3'b001, 7'd2);
        applyStimulus(1, 7'd127);
        run_request("amt127", 1, 7'd127, 16, 1'b1, 1'b0, 7'd0);
        idle_check("amt127", 1);

        // Valid held: 40 then 15 queued; 15 is taken on the edge after done.
        clear_plan();
        plan_coin(1, 3'b010, 7'd30);
        plan_coin(3, 3'b010, 7'd20);
        plan_coin(5, 3'b010, 7'd10);
        plan_coin(7, 3'b010, 7'd0);
        applyStimulus(0, 7'd40);
        run_request("amt40", 0, 7'd40, 9, 1'b0, 1'b1, 7'd15);
        clear_plan();
        plan_coin(1, 3'b010, 7'd5);
        plan_coin(3, 3'b001, 7'd0);
        run_request("amt15", 0, 7'd15, 5, 1'b0, 1'b0, 7'd0);
        idle_check("amt15", 0);

        // 125 aborted by reset after the first coin.
        applyStimulus(0, 7'd125);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(posedge clk);
        #1;
        o = obs(0);
        checkOutput("abort first coin", 32'(o[9:7]), 32'd4);
        checkOutput("abort remaining", 32'(o[6:0]), 32'd75);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", 32'(obs(0)), 32'h2000);
        @(posedge clk);
        #1;
        checkOutput("abort held", 32'(obs(0)), 32'h2000);
        @(negedge clk);
        rst_n = 1'b1;

        // First request after reset: 5 gives one coin at E1 and done at E3.
        clear_plan();
        plan_coin(1, 3'b001, 7'd0);
        applyStimulus(0, 7'd5);
        run_request("amt5", 0, 7'd5, 3, 1'b0, 1'b0, 7'd0);
        idle_check("amt5", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return transmitter on the far side of the vending machine's coin interface. The vending machine computes a change/refund amount in the same 7-bit unit scale as its `coin` bus and hands it over with a valid/ready handshake. The block decomposes the amount greedily into 50/10/5 coins and emits one single-cycle coin pulse at a time on three one-hot outputs, which mirror the `insert_coin_50/10/5` inputs the machine accepts. It drives the coin-ejector solenoids and the "change remaining" display.

## Interface
- `AMT_W`, 7: width of the amount and `remaining` buses; covers 0–127.
- `GAP`, 1: low cycles between consecutive coin pulses; legal range ≥1.

- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `refund_valid` in 1: request holds a refund amount.
- `refund_amount` in AMT_W: amount to return; sampled only at handshake.
- `refund_ready` out 1: block can accept a request; equals (state==IDLE), combinational from state.
- `coin_out_50` out 1: one-cycle pulse, eject one 50 coin.
- `coin_out_10` out 1: one-cycle pulse, eject one 10 coin.
- `coin_out_5` out 1: one-cycle pulse, eject one 5 coin.
- `remaining` out AMT_W: amount not yet ejected.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse at request completion.
- `residue_err` out 1: one-cycle pulse with `done` when the amount was not a multiple of 5.

## Operation
- States: IDLE, DISPENSE, GAP.
- IDLE:
  - Handshake when `refund_valid && refund_ready` at a rising edge.
  - On handshake: `remaining <= refund_amount`; state <= DISPENSE.
  - Without a handshake: state is held.
- DISPENSE, one decision per edge, greedy order:
  - `remaining`≥50: assert `coin_out_50`; `remaining -= 50`.
  - Else `remaining`≥10: assert `coin_out_10`; `remaining -= 10`.
  - Else `remaining`≥5: assert `coin_out_5`; `remaining -= 5`.
  - After any coin: state <= GAP, gap counter <= GAP.
  - Else (`remaining`<5): `done` <= 1; `residue_err` <= (`remaining`!=0); `remaining` <= 0; state <= IDLE.
  - Any residue below 5 is discarded, never ejected.
- GAP:
  - All coin outputs 0.
  - Counter==1: state <= DISPENSE; otherwise decrement the counter.
- Coin outputs, `done` and `residue_err` are registered and high for exactly one cycle.
- At most one coin output is high in any cycle.
- `refund_amount` changes after the handshake are ignored.
- `refund_valid` while busy is ignored. The requester holds valid; it is accepted in the cycle `done` is high, because `refund_ready` is already 1 then.
- Arithmetic: unsigned AMT_W; subtraction happens only when `remaining` ≥ the coin value, so no underflow.
- Maximum number of coins is 5 (e.g. 125 = 50+50+10+10+5).

## Timing
- Reset values while `rst_n`=0 (asynchronous):
  - State IDLE, so `refund_ready`=1 and `busy`=0.
  - All coin outputs 0, `done` 0, `residue_err` 0.
  - `remaining` 0; gap counter 0.
- Handshake at edge E0; the first coin pulse is high from E1 to E2.
- The k-th coin (k=1..n) is set at edge E(1+(k-1)(1+GAP)).
- `done` is set at edge E(1+n(1+GAP)).
- Amount <5: `done` is set at E1 with no coins.
- Back-to-back requests: the next handshake can occur at the same edge that `done` drops, i.e. one cycle after `done` is set.
- Reset mid-operation: the transfer is aborted immediately, outputs go to reset values, and the pending amount is lost. The first request after `rst_n` rises is handled normally.

## Test plan
- Reset: `rst_n`=0 mid-cycle. Required: all outputs 0 asynchronously, except `refund_ready`=1.
- Amount 65, GAP=1, handshake at E0. Required:
  - `coin_out_50` at E1, `coin_out_10` at E3, `coin_out_5` at E5.
  - `remaining` 65→15→5→0.
  - `done` at E7, `residue_err`=0.
- Amount 0 at E0. Required: `done` at E1, no coin pulse, `residue_err`=0, `busy` high for 1 cycle only.
- Amount 127, GAP=2. Required:
  - Coins 50, 50, 10, 10, 5 set at E1, E4, E7, E10, E13.
  - `done` and `residue_err` at E16; `remaining`=0 after.
- `refund_valid` held high with 40 then 15 queued:
  - 40 yields 10,10,10,10. The second request is not accepted while busy.
  - 15 is accepted at the edge after `done`, then yields 10, 5.
- Amount 125 with `rst_n` pulsed low after the first coin. Required:
  - Coins stop immediately; `remaining`=0; `refund_ready`=1.
  - A subsequent amount of 5 dispenses one `coin_out_5` at E1 and `done` at E3.
